// File: rtl/finalprojectqsys_pio_pkg.sv
// Shared definitions for the pulse-capable PIO output port: register map,
// STATUS bit positions and the pulse timer state encoding.
package finalprojectqsys_pio_pkg;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_SET       = 3'd1;
   localparam logic [2:0] ADDR_CLEAR     = 3'd2;
   localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
   localparam logic [2:0] ADDR_PULSE     = 3'd4;
   localparam logic [2:0] ADDR_STATUS    = 3'd5;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   typedef enum logic {
      TMR_IDLE = 1'b0,
      TMR_RUN  = 1'b1
   } tmr_state_e;

   function automatic logic [31:0] status_word(input logic done, input logic busy);
      logic [31:0] w;
      w                  = 32'd0;
      w[STATUS_DONE_BIT] = done;
      w[STATUS_BUSY_BIT] = busy;
      return w;
   endfunction

endpackage

// File: rtl/finalprojectqsys_pio_pulse_timer.sv
// Down-counting pulse timer: a load starts a run of len_i cycles and
// expire_o marks the edge on which the pulse ends.
module finalprojectqsys_pio_pulse_timer
   import finalprojectqsys_pio_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             busy_o,
   output logic             expire_o,
   output logic [CNT_W-1:0] count_o
);

   tmr_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             expire_s;

   // Next-state: count down in RUN, a fresh load always wins (restart)
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      expire_s = 1'b0;
      case (state_q)
         TMR_IDLE: begin
            count_d = count_q;
         end
         TMR_RUN: begin
            if (count_q == CNT_W'(1)) begin
               expire_s = 1'b1;
               count_d  = '0;
               state_d  = TMR_IDLE;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = TMR_IDLE;
            count_d = '0;
         end
      endcase
      if (load_i && (len_i != '0)) begin
         state_d = TMR_RUN;
         count_d = len_i;
      end else begin
         state_d = state_d;
      end
   end

   // State and counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= TMR_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign busy_o   = (state_q == TMR_RUN);
   assign expire_o = expire_s;
   assign count_o  = count_q;

endmodule

// File: rtl/finalprojectqsys_pio_pulse_out.sv
// Avalon-MM output port with atomic set/clear and a hardware-timed pulse
// that auto-clears selected bits and raises a sticky done/irq.
module finalprojectqsys_pio_pulse_out
   import finalprojectqsys_pio_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int CNT_W         = 16,
   parameter int RESET_VALUE   = 0,
   parameter int DEFAULT_PULSE = 1000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_port,
   output logic              irq
);

   localparam logic [DATA_W-1:0] RESET_DATA = DATA_W'(RESET_VALUE);
   localparam logic [CNT_W-1:0]  RESET_LEN  = CNT_W'(DEFAULT_PULSE);

   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [DATA_W-1:0] pulse_mask_q, pulse_mask_d;
   logic [CNT_W-1:0]  pulse_len_q, pulse_len_d;
   logic              done_q, done_d;

   logic              wr_s;
   logic [DATA_W-1:0] wr_mask_s;
   logic              load_s;
   logic              busy_s;
   logic              expire_s;
   logic [CNT_W-1:0]  count_s;
   logic              wdata_unused_s;

   assign wr_s           = chipselect & ~write_n;
   assign wr_mask_s      = writedata[DATA_W-1:0];
   assign wdata_unused_s = ^writedata;

   finalprojectqsys_pio_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (load_s),
      .len_i    (pulse_len_q),
      .busy_o   (busy_s),
      .expire_o (expire_s),
      .count_o  (count_s)
   );

   // Expiry clear is applied first so a same-cycle write wins on overlapping bits
   always_comb begin
      data_out_d   = data_out_q;
      pulse_mask_d = pulse_mask_q;
      pulse_len_d  = pulse_len_q;
      done_d       = done_q;
      load_s       = 1'b0;
      if (expire_s) begin
         data_out_d   = data_out_q & ~pulse_mask_q;
         pulse_mask_d = '0;
      end else begin
         data_out_d = data_out_q;
      end
      if (wr_s) begin
         case (address)
            ADDR_DATA:      data_out_d  = wr_mask_s;
            ADDR_SET:       data_out_d  = data_out_d | wr_mask_s;
            ADDR_CLEAR:     data_out_d  = data_out_d & ~wr_mask_s;
            ADDR_PULSE_LEN: pulse_len_d = writedata[CNT_W-1:0];
            ADDR_PULSE: begin
               if (wr_mask_s != '0) begin
                  data_out_d = data_out_d | wr_mask_s;
                  if (pulse_len_q != '0) begin
                     pulse_mask_d = wr_mask_s;
                     load_s       = 1'b1;
                  end else begin
                     load_s = 1'b0;
                  end
               end else begin
                  load_s = 1'b0;
               end
            end
            ADDR_STATUS: begin
               if (writedata[STATUS_DONE_BIT]) begin
                  done_d = 1'b0;
               end else begin
                  done_d = done_q;
               end
            end
            default: begin
               data_out_d = data_out_d;
            end
         endcase
      end else begin
         load_s = 1'b0;
      end
      // A completing pulse beats a simultaneous software clear
      if (expire_s) begin
         done_d = 1'b1;
      end else begin
         done_d = done_d;
      end
   end

   // Port register state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q   <= RESET_DATA;
         pulse_mask_q <= '0;
         pulse_len_q  <= RESET_LEN;
         done_q       <= 1'b0;
      end else begin
         data_out_q   <= data_out_d;
         pulse_mask_q <= pulse_mask_d;
         pulse_len_q  <= pulse_len_d;
         done_q       <= done_d;
      end
   end

   // Zero-wait-state read mux
   always_comb begin
      readdata = 32'd0;
      case (address)
         ADDR_DATA:      readdata = 32'(data_out_q);
         ADDR_PULSE_LEN: readdata = 32'(pulse_len_q);
         ADDR_PULSE:     readdata = 32'(count_s);
         ADDR_STATUS:    readdata = status_word(done_q, busy_s);
         default:        readdata = 32'd0;
      endcase
   end

   assign out_port = data_out_q;
   assign irq      = done_q;

endmodule

// File: tb/tb_finalprojectqsys_pio_pulse_out.sv
// Directed bench for the pulse-capable PIO port; inputs change on the falling
// edge and outputs are compared on the falling edge after each capture.
module tb_finalprojectqsys_pio_pulse_out;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   logic              clk;
   logic              reset_n;
   logic [2:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic [DATA_W-1:0] out_port;
   logic              irq;

   int vec_cnt;
   int err_cnt;

   finalprojectqsys_pio_pulse_out #(
      .DATA_W        (DATA_W),
      .CNT_W         (CNT_W),
      .RESET_VALUE   (32'hA5),
      .DEFAULT_PULSE (1000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one write at the current falling edge; returns after it is captured
   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;
      vec_cnt    = 0;
      err_cnt    = 0;
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      idle(2);
      reset_n = 1'b1;
      idle(1);

      // Reset state
      check_vec("rst_out", 32'(out_port), 32'h0000_00A5);
      bus_rd(3'd3, rd); check_vec("rst_len", rd, 32'd1000);
      check_vec("rst_irq", 32'(irq), 32'd0);

      // Reset in the middle of a pulse
      bus_wr(3'd3, 32'd20);
      bus_wr(3'd4, 32'h0000_0050);
      check_vec("mid_out", 32'(out_port), 32'h0000_00F5);
      idle(3);
      reset_n = 1'b0;
      #1;
      check_vec("arst_out", 32'(out_port), 32'h0000_00A5);
      bus_rd(3'd5, rd); check_vec("arst_status", rd, 32'd0);
      bus_rd(3'd3, rd); check_vec("arst_len", rd, 32'd1000);
      idle(1);
      reset_n = 1'b1;
      idle(1);

      // DATA / SET / CLEAR
      bus_wr(3'd0, 32'h0000_003C); check_vec("data", 32'(out_port), 32'h0000_003C);
      bus_wr(3'd1, 32'h0000_00C0); check_vec("set", 32'(out_port), 32'h0000_00FC);
      bus_wr(3'd2, 32'h0000_000C); check_vec("clear", 32'(out_port), 32'h0000_00F0);
      bus_rd(3'd1, rd); check_vec("rd_set", rd, 32'd0);
      bus_rd(3'd2, rd); check_vec("rd_clr", rd, 32'd0);
      bus_rd(3'd0, rd); check_vec("rd_data", rd, 32'h0000_00F0);

      // Basic 5-cycle pulse on bit0
      bus_wr(3'd0, 32'd0);
      bus_wr(3'd3, 32'd5);
      bus_wr(3'd4, 32'h0000_0001);
      check_vec("p5_c0", 32'(out_port), 32'h0000_0001);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         check_vec("p5_hold", {31'd0, irq} | 32'(out_port), 32'h0000_0001);
      end
      @(negedge clk);
      check_vec("p5_drop", 32'(out_port), 32'd0);
      check_vec("p5_irq", 32'(irq), 32'd1);
      bus_rd(3'd5, rd); check_vec("p5_status", rd, 32'd2);
      bus_wr(3'd5, 32'd2);
      check_vec("p5_irqclr", 32'(irq), 32'd0);

      // Restart while running
      bus_wr(3'd3, 32'd10);
      bus_wr(3'd4, 32'h0000_0001);
      bus_rd(3'd4, rd); check_vec("rs_cnt10", rd, 32'd10);
      idle(6);
      bus_rd(3'd4, rd); check_vec("rs_cnt4", rd, 32'd4);
      bus_wr(3'd4, 32'h0000_0002);
      check_vec("rs_both", 32'(out_port), 32'h0000_0003);
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         check_vec("rs_hold", {31'd0, irq} | 32'(out_port), 32'h0000_0003);
      end
      @(negedge clk);
      check_vec("rs_drop", 32'(out_port), 32'h0000_0001);
      bus_rd(3'd5, rd); check_vec("rs_status", rd, 32'd2);
      bus_wr(3'd5, 32'd2);

      // SET on the pulsed bit in the expiry cycle
      bus_wr(3'd0, 32'd0);
      bus_wr(3'd3, 32'd3);
      bus_wr(3'd4, 32'h0000_0001);
      idle(2);
      bus_rd(3'd4, rd); check_vec("ex_cnt1", rd, 32'd1);
      bus_wr(3'd1, 32'h0000_0001);
      check_vec("ex_out", 32'(out_port), 32'h0000_0001);
      bus_rd(3'd5, rd); check_vec("ex_status", rd, 32'd2);
      bus_wr(3'd5, 32'd2);

      // STATUS clear in the expiry cycle leaves done set
      bus_wr(3'd4, 32'h0000_0002);
      idle(2);
      bus_wr(3'd5, 32'd2);
      check_vec("dc_irq", 32'(irq), 32'd1);
      check_vec("dc_out", 32'(out_port), 32'h0000_0001);
      bus_wr(3'd5, 32'd2);
      check_vec("dc_irqclr", 32'(irq), 32'd0);

      // Zero length and zero mask
      bus_wr(3'd0, 32'd0);
      bus_wr(3'd3, 32'd0);
      bus_wr(3'd4, 32'h0000_0080);
      check_vec("z_out", 32'(out_port), 32'h0000_0080);
      bus_rd(3'd5, rd); check_vec("z_status", rd, 32'd0);
      bus_wr(3'd4, 32'd0);
      check_vec("zm_out", 32'(out_port), 32'h0000_0080);
      bus_rd(3'd5, rd); check_vec("zm_status", rd, 32'd0);
      bus_rd(3'd4, rd); check_vec("zm_cnt", rd, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
